if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage between the program counter and the ID stage.
- Takes the current instruction address from the PC and runs a req/ack handshake with instruction memory.
- Registers the returned instruction plus PC+1 into the IF/ID boundary.
- Raises a stall so the pipeline controller pauses the PC while memory is slow or ID is stalled. Handles jump flushes, including a flush that arrives while a request is outstanding.

Parameters:
- DATA_W, 32, width of instruction and address words (word addressed, PC+1 per instruction).
- NOP_INST, 32'h0000_0000, instruction word driven on inst_o when the slot is invalid/flushed.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- pc_i  in  DATA_W  current instruction address from PC.
- flush_i  in  1  jump taken in ID; PC loads the target at this edge regardless of fetch_stall_o.
- id_stall_i  in  1  ID cannot accept a new instruction this cycle.
- mem_req_o  out  1  instruction-memory request.
- mem_addr_o  out  DATA_W  request address; stable while mem_req_o high until ack.
- mem_ack_i  in  1  memory returns mem_rdata_i this cycle (single-cycle pulse per request).
- mem_rdata_i  in  DATA_W  instruction data, valid with mem_ack_i.
- fetch_stall_o  out  1  to controller: select PAUSE for PC this cycle.
- inst_o  out  DATA_W  IF/ID instruction.
- pc_plus_one_o  out  DATA_W  IF/ID PC+1 of inst_o.
- valid_o  out  1  inst_o holds a real instruction.

Behaviour:
- States: IDLE, REQ, DROP, FULL. Reset: state IDLE; inst_o=NOP_INST, pc_plus_one_o=0, valid_o=0, buffer empty, addr_q=0. Reset dominates every other input.
- IDLE: mem_req_o=0, fetch_stall_o=1. Always -> REQ on the next edge (one dead cycle after reset).
- REQ: mem_req_o=1, mem_addr_o=pc_i, addr_q<=pc_i every cycle.
  - flush_i=1: valid_o<=0, inst_o<=NOP_INST, any ack data discarded. Go DROP if mem_ack_i=0, else stay REQ.
  - ack and !id_stall_i: inst_o<=mem_rdata_i, pc_plus_one_o<=pc_i+1 (mod 2^DATA_W, 32'hFFFF_FFFF wraps to 0), valid_o<=1, fetch_stall_o=0 (PC advances). Stay REQ; back-to-back single-cycle fetches sustain one instruction per cycle.
  - ack and id_stall_i: buffer<=(mem_rdata_i, pc_i+1), fetch_stall_o=0, outputs held -> FULL.
  - no ack: fetch_stall_o=1. If id_stall_i, hold outputs; else valid_o<=0 (bubble), inst_o<=NOP_INST.
- DROP: mem_req_o=1, mem_addr_o=addr_q (old address held for the memory rule), fetch_stall_o=1, valid_o=0.
  - On ack: data discarded -> REQ (fetches new pc_i next cycle).
  - A further flush_i in DROP is a no-op beyond keeping valid_o=0.
- FULL: mem_req_o=0, fetch_stall_o=1.
  - flush_i: buffer cleared, valid_o<=0 -> REQ.
  - Else if !id_stall_i: outputs<=buffer, valid_o<=1 -> REQ.
  - Else hold.
- Priority in every state: rst > flush_i > id_stall_i > mem_ack_i.
- fetch_stall_o and mem_req_o are combinational from state/inputs. All IF/ID outputs are registered.
- At most one outstanding request. mem_ack_i outside REQ/DROP is ignored.

Decomposition:
- Shared defines file: state encodings (IF_IDLE, IF_REQ, IF_DROP, IF_FULL, 2 bits), NOP_INST value, existing PcOp encodings used by the controller.
- One natural sub-module: if_skid_buf, a one-entry (inst, pc+1) holding register with load/clear/valid. The FSM and IF/ID registers stay in if_fetch.

Test Plan:
- Reset released, memory acks same cycle: pc_i 0,1,2 -> after IDLE cycle, valid_o=1 with inst=mem[0],mem[1],mem[2] and pc_plus_one_o=1,2,3 on consecutive cycles; fetch_stall_o=0 throughout.
- Ack delayed 3 cycles at pc_i=5 -> fetch_stall_o=1 and valid_o=0 for 3 cycles, mem_addr_o=5 stable; then inst_o=mem[5], pc_plus_one_o=6.
- Flush while request at pc=8 is outstanding, target 20 -> DROP keeps mem_addr_o=8 until ack, data discarded (valid_o stays 0); next request addr 20, inst_o=mem[20].
- Ack at pc=3 with id_stall_i high 2 cycles -> outputs hold previous instruction, mem_req_o=0; on release inst_o=mem[3], pc_plus_one_o=4; no duplicate or lost instruction.
- Flush in FULL -> buffered instruction dropped, valid_o=0, next fetch from new pc_i.
- Reset asserted in DROP and in FULL -> next cycle state IDLE, valid_o=0, inst_o=0, mem_req_o=0; pc_i=32'hFFFF_FFFF fetch -> pc_plus_one_o=0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int unsigned IF_DATA_W = 32;
  localparam logic [IF_DATA_W-1:0] IF_NOP_INST = 32'h0000_0000;

  // Fetch FSM state encodings.
  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_DROP = 2'd2,
    IF_FULL = 2'd3
  } if_state_e;

  // PC update selections driven by the pipeline controller.
  typedef enum logic [1:0] {
    PC_OP_NEXT  = 2'd0,
    PC_OP_PAUSE = 2'd1,
    PC_OP_JUMP  = 2'd2,
    PC_OP_RESET = 2'd3
  } pc_op_e;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetched (inst, pc+1) pair while ID is stalled.
module if_skid_buf
  import if_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = IF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] inst_i,
  input  logic [DATA_W-1:0] pc_plus_one_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [DATA_W-1:0] pc_plus_one_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] inst_q;
  logic [DATA_W-1:0] pc_plus_one_q;
  logic              valid_q;

  // Capture on load, empty on clear or reset.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      inst_q        <= '0;
      pc_plus_one_q <= '0;
      valid_q       <= 1'b0;
    end else if (load_i) begin
      inst_q        <= inst_i;
      pc_plus_one_q <= pc_plus_one_i;
      valid_q       <= 1'b1;
    end
  end

  assign inst_o        = inst_q;
  assign pc_plus_one_o = pc_plus_one_q;
  assign valid_o       = valid_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: memory req/ack handshake, IF/ID registers, stall and flush handling.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned       DATA_W   = IF_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(IF_NOP_INST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              flush_i,
  input  logic              id_stall_i,
  output logic              mem_req_o,
  output logic [DATA_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              fetch_stall_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [DATA_W-1:0] pc_plus_one_o,
  output logic              valid_o
);

  if_state_e         state_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] inst_q;
  logic [DATA_W-1:0] pc_plus_one_q;
  logic              valid_q;
  logic [DATA_W-1:0] pc_plus_one_d;

  logic              buf_load;
  logic              buf_clear;
  logic [DATA_W-1:0] buf_inst;
  logic [DATA_W-1:0] buf_pc_plus_one;
  logic              buf_valid;

  assign pc_plus_one_d = pc_i + DATA_W'(1);

  if_skid_buf #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk          (clk),
    .rst          (rst),
    .load_i       (buf_load),
    .clear_i      (buf_clear),
    .inst_i       (mem_rdata_i),
    .pc_plus_one_i(pc_plus_one_d),
    .inst_o       (buf_inst),
    .pc_plus_one_o(buf_pc_plus_one),
    .valid_o      (buf_valid)
  );

  // Memory request, PC pause and skid-buffer control from current state and inputs.
  always_comb begin
    mem_req_o     = 1'b0;
    mem_addr_o    = pc_i;
    fetch_stall_o = 1'b1;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;
    case (state_q)
      IF_REQ: begin
        mem_req_o = 1'b1;
        if (!flush_i && mem_ack_i) begin
          fetch_stall_o = 1'b0;
          buf_load      = id_stall_i;
        end
      end
      IF_DROP: begin
        // Keep presenting the abandoned address until memory answers it.
        mem_req_o  = 1'b1;
        mem_addr_o = addr_q;
      end
      IF_FULL: begin
        buf_clear = flush_i || !id_stall_i;
      end
      default: ;
    endcase
  end

  // Fetch FSM and IF/ID registers; priority is flush, then ID stall, then ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IF_IDLE;
      addr_q        <= '0;
      inst_q        <= NOP_INST;
      pc_plus_one_q <= '0;
      valid_q       <= 1'b0;
    end else begin
      case (state_q)
        IF_IDLE: begin
          state_q <= IF_REQ;
        end
        IF_REQ: begin
          addr_q <= pc_i;
          if (flush_i) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            if (!mem_ack_i) begin
              state_q <= IF_DROP;
            end
          end else if (id_stall_i) begin
            if (mem_ack_i) begin
              state_q <= IF_FULL;
            end
          end else if (mem_ack_i) begin
            inst_q        <= mem_rdata_i;
            pc_plus_one_q <= pc_plus_one_d;
            valid_q       <= 1'b1;
          end else begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
          end
        end
        IF_DROP: begin
          valid_q <= 1'b0;
          inst_q  <= NOP_INST;
          if (mem_ack_i) begin
            state_q <= IF_REQ;
          end
        end
        IF_FULL: begin
          if (flush_i) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            state_q <= IF_REQ;
          end else if (!id_stall_i) begin
            inst_q        <= buf_inst;
            pc_plus_one_q <= buf_pc_plus_one;
            valid_q       <= buf_valid;
            state_q       <= IF_REQ;
          end
        end
        default: begin
          state_q <= IF_IDLE;
        end
      endcase
    end
  end

  assign inst_o        = inst_q;
  assign pc_plus_one_o = pc_plus_one_q;
  assign valid_o       = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus a randomized run against a PC/memory/stream model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        flush_i = 1'b0;
  logic        id_stall_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        fetch_stall_o;
  logic [31:0] inst_o;
  logic [31:0] pc_plus_one_o;
  logic        valid_o;

  int unsigned n_pass = 0;
  int unsigned n_chk = 0;
  int unsigned lat_cur = 0;
  int unsigned wait_cnt = 0;

  if_fetch #(
    .DATA_W  (32),
    .NOP_INST(IF_NOP_INST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .id_stall_i   (id_stall_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .fetch_stall_o(fetch_stall_o),
    .inst_o       (inst_o),
    .pc_plus_one_o(pc_plus_one_o),
    .valid_o      (valid_o)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Memory: acks once a request has waited lat_cur cycles.
  assign mem_ack_i   = mem_req_o && (wait_cnt >= lat_cur);
  assign mem_rdata_i = memval(mem_addr_o);

  always @(posedge clk) begin
    if (rst) wait_cnt <= 0;
    else if (mem_ack_i) wait_cnt <= 0;
    else if (mem_req_o) wait_cnt <= wait_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  // One clock cycle: drive inputs just after the edge, return at the following negedge.
  task automatic cyc(input logic r, input logic [31:0] pc, input logic fl, input logic st,
                     input int unsigned lat);
    @(posedge clk);
    #1;
    rst        = r;
    pc_i       = pc;
    flush_i    = fl;
    id_stall_i = st;
    lat_cur    = lat;
    @(negedge clk);
  endtask

  // Leaves the DUT in its post-reset dead cycle; the next cyc() is the first request cycle.
  task automatic do_reset(input logic [31:0] pc, input int unsigned lat);
    cyc(1'b1, pc, 1'b0, 1'b0, lat);
    cyc(1'b1, pc, 1'b0, 1'b0, lat);
    cyc(1'b0, pc, 1'b0, 1'b0, lat);
  endtask

  task automatic test_reset();
    do_reset(32'd0, 0);
    n_chk++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else n_pass++;
    n_chk++; if (inst_o !== IF_NOP_INST) $display("FAIL reset_inst: got %h want %h", inst_o, IF_NOP_INST); else n_pass++;
    n_chk++; if (pc_plus_one_o !== 32'd0) $display("FAIL reset_pc1: got %h want 0", pc_plus_one_o); else n_pass++;
    n_chk++; if (mem_req_o !== 1'b0) $display("FAIL reset_req: got %b want 0", mem_req_o); else n_pass++;
    n_chk++; if (fetch_stall_o !== 1'b1) $display("FAIL reset_stall: got %b want 1", fetch_stall_o); else n_pass++;
  endtask

  task automatic test_stream();
    do_reset(32'd0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'(i), 1'b0, 1'b0, 0);
      n_chk++; if (fetch_stall_o !== 1'b0) $display("FAIL stream_stall[%0d]: got %b want 0", i, fetch_stall_o); else n_pass++;
      n_chk++; if (mem_addr_o !== 32'(i)) $display("FAIL stream_addr[%0d]: got %h want %h", i, mem_addr_o, 32'(i)); else n_pass++;
      if (i > 0) begin
        n_chk++; if (inst_o !== memval(32'(i - 1))) $display("FAIL stream_inst[%0d]: got %h want %h", i, inst_o, memval(32'(i - 1))); else n_pass++;
        n_chk++; if (pc_plus_one_o !== 32'(i)) $display("FAIL stream_pc1[%0d]: got %h want %h", i, pc_plus_one_o, 32'(i)); else n_pass++;
        n_chk++; if (valid_o !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", i, valid_o); else n_pass++;
      end
    end
  endtask

  task automatic test_delayed_ack();
    do_reset(32'd4, 0);
    cyc(1'b0, 32'd4, 1'b0, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 32'd5, 1'b0, 1'b0, 3);
      n_chk++; if (mem_addr_o !== 32'd5) $display("FAIL delay_addr[%0d]: got %h want 5", k, mem_addr_o); else n_pass++;
      n_chk++; if (fetch_stall_o !== 1'(k < 3)) $display("FAIL delay_stall[%0d]: got %b want %b", k, fetch_stall_o, 1'(k < 3)); else n_pass++;
      n_chk++; if (valid_o !== 1'(k == 0)) $display("FAIL delay_valid[%0d]: got %b want %b", k, valid_o, 1'(k == 0)); else n_pass++;
    end
    cyc(1'b0, 32'd6, 1'b0, 1'b0, 3);
    n_chk++; if (inst_o !== memval(32'd5)) $display("FAIL delay_inst: got %h want %h", inst_o, memval(32'd5)); else n_pass++;
    n_chk++; if (pc_plus_one_o !== 32'd6) $display("FAIL delay_pc1: got %h want 6", pc_plus_one_o); else n_pass++;
    n_chk++; if (valid_o !== 1'b1) $display("FAIL delay_valid_end: got %b want 1", valid_o); else n_pass++;
  endtask

  task automatic test_flush_outstanding();
    do_reset(32'd8, 3);
    cyc(1'b0, 32'd8, 1'b0, 1'b0, 3);
    cyc(1'b0, 32'd8, 1'b1, 1'b0, 3);
    for (int d = 0; d < 2; d++) begin
      cyc(1'b0, 32'd20, 1'b0, 1'b0, 3);
      n_chk++; if (mem_req_o !== 1'b1) $display("FAIL drop_req[%0d]: got %b want 1", d, mem_req_o); else n_pass++;
      n_chk++; if (mem_addr_o !== 32'd8) $display("FAIL drop_addr[%0d]: got %h want 8", d, mem_addr_o); else n_pass++;
      n_chk++; if (valid_o !== 1'b0) $display("FAIL drop_valid[%0d]: got %b want 0", d, valid_o); else n_pass++;
      n_chk++; if (fetch_stall_o !== 1'b1) $display("FAIL drop_stall[%0d]: got %b want 1", d, fetch_stall_o); else n_pass++;
    end
    cyc(1'b0, 32'd20, 1'b0, 1'b0, 0);
    n_chk++; if (mem_addr_o !== 32'd20) $display("FAIL drop_newaddr: got %h want 20", mem_addr_o); else n_pass++;
    n_chk++; if (valid_o !== 1'b0) $display("FAIL drop_discard_valid: got %b want 0", valid_o); else n_pass++;
    n_chk++; if (inst_o !== IF_NOP_INST) $display("FAIL drop_discard_inst: got %h want %h", inst_o, IF_NOP_INST); else n_pass++;
    cyc(1'b0, 32'd21, 1'b0, 1'b0, 0);
    n_chk++; if (inst_o !== memval(32'd20)) $display("FAIL drop_inst: got %h want %h", inst_o, memval(32'd20)); else n_pass++;
    n_chk++; if (pc_plus_one_o !== 32'd21) $display("FAIL drop_pc1: got %h want 21", pc_plus_one_o); else n_pass++;
  endtask

  task automatic test_id_stall();
    do_reset(32'd2, 0);
    cyc(1'b0, 32'd2, 1'b0, 1'b0, 0);
    cyc(1'b0, 32'd3, 1'b0, 1'b1, 0);
    n_chk++; if (fetch_stall_o !== 1'b0) $display("FAIL full_ack_stall: got %b want 0", fetch_stall_o); else n_pass++;
    cyc(1'b0, 32'd4, 1'b0, 1'b1, 0);
    n_chk++; if (mem_req_o !== 1'b0) $display("FAIL full_req: got %b want 0", mem_req_o); else n_pass++;
    n_chk++; if (fetch_stall_o !== 1'b1) $display("FAIL full_stall: got %b want 1", fetch_stall_o); else n_pass++;
    n_chk++; if (inst_o !== memval(32'd2)) $display("FAIL full_hold_inst: got %h want %h", inst_o, memval(32'd2)); else n_pass++;
    n_chk++; if (pc_plus_one_o !== 32'd3) $display("FAIL full_hold_pc1: got %h want 3", pc_plus_one_o); else n_pass++;
    cyc(1'b0, 32'd4, 1'b0, 1'b0, 0);
    n_chk++; if (inst_o !== memval(32'd2)) $display("FAIL full_hold2_inst: got %h want %h", inst_o, memval(32'd2)); else n_pass++;
    cyc(1'b0, 32'd4, 1'b0, 1'b0, 0);
    n_chk++; if (inst_o !== memval(32'd3)) $display("FAIL full_drain_inst: got %h want %h", inst_o, memval(32'd3)); else n_pass++;
    n_chk++; if (pc_plus_one_o !== 32'd4) $display("FAIL full_drain_pc1: got %h want 4", pc_plus_one_o); else n_pass++;
    n_chk++; if (mem_addr_o !== 32'd4) $display("FAIL full_next_addr: got %h want 4", mem_addr_o); else n_pass++;
    cyc(1'b0, 32'd5, 1'b0, 1'b0, 0);
    n_chk++; if (inst_o !== memval(32'd4)) $display("FAIL full_next_inst: got %h want %h", inst_o, memval(32'd4)); else n_pass++;
    n_chk++; if (pc_plus_one_o !== 32'd5) $display("FAIL full_next_pc1: got %h want 5", pc_plus_one_o); else n_pass++;
  endtask

  task automatic test_flush_full();
    do_reset(32'd2, 0);
    cyc(1'b0, 32'd2, 1'b0, 1'b0, 0);
    cyc(1'b0, 32'd3, 1'b0, 1'b1, 0);
    cyc(1'b0, 32'd4, 1'b1, 1'b1, 0);
    n_chk++; if (mem_req_o !== 1'b0) $display("FAIL ffull_req: got %b want 0", mem_req_o); else n_pass++;
    cyc(1'b0, 32'd30, 1'b0, 1'b0, 0);
    n_chk++; if (valid_o !== 1'b0) $display("FAIL ffull_valid: got %b want 0", valid_o); else n_pass++;
    n_chk++; if (inst_o !== IF_NOP_INST) $display("FAIL ffull_inst: got %h want %h", inst_o, IF_NOP_INST); else n_pass++;
    n_chk++; if (mem_addr_o !== 32'd30) $display("FAIL ffull_addr: got %h want 30", mem_addr_o); else n_pass++;
    cyc(1'b0, 32'd31, 1'b0, 1'b0, 0);
    n_chk++; if (inst_o !== memval(32'd30)) $display("FAIL ffull_new_inst: got %h want %h", inst_o, memval(32'd30)); else n_pass++;
    n_chk++; if (pc_plus_one_o !== 32'd31) $display("FAIL ffull_new_pc1: got %h want 31", pc_plus_one_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    // Reset while dropping an abandoned request.
    do_reset(32'd8, 3);
    cyc(1'b0, 32'd8, 1'b0, 1'b0, 3);
    cyc(1'b0, 32'd8, 1'b1, 1'b0, 3);
    cyc(1'b1, 32'd20, 1'b0, 1'b0, 3);
    n_chk++; if (mem_addr_o !== 32'd8) $display("FAIL rdrop_pre_addr: got %h want 8", mem_addr_o); else n_pass++;
    cyc(1'b0, 32'd20, 1'b0, 1'b0, 3);
    n_chk++; if (mem_req_o !== 1'b0) $display("FAIL rdrop_req: got %b want 0", mem_req_o); else n_pass++;
    n_chk++; if (valid_o !== 1'b0) $display("FAIL rdrop_valid: got %b want 0", valid_o); else n_pass++;
    n_chk++; if (inst_o !== IF_NOP_INST) $display("FAIL rdrop_inst: got %h want %h", inst_o, IF_NOP_INST); else n_pass++;
    // Reset while holding a buffered instruction.
    do_reset(32'd2, 0);
    cyc(1'b0, 32'd2, 1'b0, 1'b0, 0);
    cyc(1'b0, 32'd3, 1'b0, 1'b1, 0);
    cyc(1'b1, 32'd4, 1'b0, 1'b1, 0);
    n_chk++; if (valid_o !== 1'b1) $display("FAIL rfull_pre_valid: got %b want 1", valid_o); else n_pass++;
    cyc(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    n_chk++; if (mem_req_o !== 1'b0) $display("FAIL rfull_req: got %b want 0", mem_req_o); else n_pass++;
    n_chk++; if (valid_o !== 1'b0) $display("FAIL rfull_valid: got %b want 0", valid_o); else n_pass++;
    n_chk++; if (pc_plus_one_o !== 32'd0) $display("FAIL rfull_pc1: got %h want 0", pc_plus_one_o); else n_pass++;
    // Fetch at the top of the address space wraps PC+1 to zero.
    cyc(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 0);
    n_chk++; if (pc_plus_one_o !== 32'd0) $display("FAIL wrap_pc1: got %h want 0", pc_plus_one_o); else n_pass++;
    n_chk++; if (inst_o !== memval(32'hFFFF_FFFF)) $display("FAIL wrap_inst: got %h want %h", inst_o, memval(32'hFFFF_FFFF)); else n_pass++;
    n_chk++; if (valid_o !== 1'b1) $display("FAIL wrap_valid: got %b want 1", valid_o); else n_pass++;
  endtask

  // Random latency, ID stalls and jumps; every accepted fetch must reach ID once, in order.
  task automatic test_random();
    logic [63:0]  exp_q[$];
    logic [63:0]  e;
    logic [31:0]  pc;
    logic [31:0]  pend_addr;
    logic         pend;
    logic         fl;
    logic         st;
    int unsigned  lat;
    int unsigned  consumed;
    pc = '0; pend = 1'b0; pend_addr = '0; lat = 0; consumed = 0;
    do_reset(32'd0, 0);
    for (int n = 0; n < 500; n++) begin
      fl = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 3) == 0);
      if (!pend) lat = $urandom_range(0, 3);
      cyc(1'b0, pc, fl, st, lat);
      if (!valid_o) begin
        n_chk++; if (inst_o !== IF_NOP_INST) $display("FAIL rnd_bubble_inst[%0d]: got %h want %h", n, inst_o, IF_NOP_INST); else n_pass++;
      end
      if (pend && mem_req_o) begin
        n_chk++; if (mem_addr_o !== pend_addr) $display("FAIL rnd_addr_stable[%0d]: got %h want %h", n, mem_addr_o, pend_addr); else n_pass++;
      end
      if (!fetch_stall_o) begin
        n_chk++; if (mem_addr_o !== pc) $display("FAIL rnd_fetch_addr[%0d]: got %h want %h", n, mem_addr_o, pc); else n_pass++;
      end
      if (!st && !fl && valid_o) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL rnd_spurious[%0d]: got inst %h with nothing expected", n, inst_o);
        end else begin
          e = exp_q.pop_front();
          if ({inst_o, pc_plus_one_o} !== e)
            $display("FAIL rnd_stream[%0d]: got %h/%h want %h/%h", n, inst_o, pc_plus_one_o, e[63:32], e[31:0]);
          else n_pass++;
          consumed++;
        end
      end
      if (fl) begin
        exp_q.delete();
        pc = 32'($urandom_range(0, 255));
      end else if (!fetch_stall_o) begin
        exp_q.push_back({memval(pc), pc + 32'd1});
        pc = pc + 32'd1;
      end
      pend      = mem_req_o && !mem_ack_i;
      pend_addr = mem_addr_o;
    end
    n_chk++; if (consumed < 30) $display("FAIL rnd_progress: got %0d instructions want at least 30", consumed); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_delayed_ack();
    test_flush_outstanding();
    test_id_stall();
    test_flush_full();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
